mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single Data_Memory between the instruction cache (port 0, read-only) and dcache_top (port 1, read/write).
- Sits between both cache controllers and Data_Memory. Presents each cache with a private memory-like handshake: enable, write, addr, data, ack.
- Serialises whole cache-line transactions with round-robin fairness, and flags a memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width on all ports.
- LINE_W, 256, cache-line data width.
- TIMEOUT, 64, cycles in a BUSY state without mem_ack_i before err_o sets; must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m0_enable_i  in  1  instruction-cache request.
- m0_addr_i  in  ADDR_W  instruction-cache line address.
- m0_ack_o  out  1  instruction-cache completion pulse.
- m0_data_o  out  LINE_W  instruction-cache read data.
- m1_enable_i  in  1  data-cache request.
- m1_write_i  in  1  data-cache write (1) / read (0).
- m1_addr_i  in  ADDR_W  data-cache line address.
- m1_data_i  in  LINE_W  data-cache write line.
- m1_ack_o  out  1  data-cache completion pulse.
- m1_data_o  out  LINE_W  data-cache read data.
- mem_enable_o  out  1  to Data_Memory enable_i.
- mem_write_o  out  1  to Data_Memory write_i.
- mem_addr_o  out  ADDR_W  to Data_Memory addr_i.
- mem_data_o  out  LINE_W  to Data_Memory data_i.
- mem_ack_i  in  1  from Data_Memory ack_o.
- mem_data_i  in  LINE_W  from Data_Memory data_o.
- grant_o  out  2  one-hot current owner; 00 when idle.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (synchronous, applies on any cycle including mid-transaction):
  - State goes to IDLE; last_grant goes to 1, so port 0 wins the first tie.
  - Timeout counter and err_o clear.
  - All mem_* outputs, acks and grant_o are 0.
  - An in-flight memory transaction is abandoned. No ack is forwarded; a late mem_ack_i is ignored.
- States:
  - IDLE: no grant.
  - BUSY0: port 0 owns memory.
  - BUSY1: port 1 owns memory.
- IDLE transitions, evaluated on enables sampled at edge t:
  - Only m0 requesting: BUSY0.
  - Only m1 requesting: BUSY1.
  - Both requesting: grant the port ≠ last_grant.
  - Neither requesting: stay in IDLE.
- Request capture at the grant edge:
  - Address, write and data are latched into holding registers.
  - Port 0's write is forced to 0.
  - Later changes on m*_addr/data/write have no effect on the transaction.
- Memory outputs:
  - In BUSYx, all mem_* outputs are registered from the holding registers; mem_enable_o = 1 from cycle t+1.
  - Latency is 1 cycle from request to mem_enable_o.
  - In IDLE, all mem_* outputs are 0.
- Completion:
  - In BUSYx with mem_ack_i = 1, mx_ack_o = 1 combinationally in that same cycle and mx_data_o = mem_data_i.
  - Next state is IDLE; last_grant updates to x; mem_enable_o drops at the next edge.
  - m*_data_o passes mem_data_i through and is valid only while that port's ack is high.
  - The ack of the non-owner port is always 0.
- Requester rule: a requester deasserts enable in the cycle after its ack, or issues a new request.
  - A requester still asserting enable in IDLE is treated as a new request.
  - Minimum turnaround is one IDLE cycle between transactions.
- Enable dropped while BUSYx: the transaction still completes; the ack pulse is still issued; no cancel.
- mem_ack_i while IDLE: ignored.
- Timeout:
  - A counter clears on entry to BUSYx and increments each BUSY cycle without ack.
  - Reaching TIMEOUT sets err_o, which is sticky until rst_i.
  - The arbiter remains in BUSYx waiting for ack; there is no forced release.
  - The counter saturates and does not wrap.
- grant_o: 01 in BUSY0, 10 in BUSY1, 00 in IDLE.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding: IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2.
  - Port index constants.
  - Default ADDR_W / LINE_W.
- Natural sub-module: rr_pick2, a combinational round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot grant.
  - Reusable for later arbiters.
- Remaining FSM, holding registers and timeout counter stay in mem_arbiter.

Test Plan:
- Reset then single read: m1 read at addr 0x0000_0400 → mem_enable_o = 1, mem_write_o = 0, mem_addr_o = 0x400 one cycle later. Memory acks after 10 cycles with line 0xAA..AA → m1_ack_o one-cycle pulse, m1_data_o = 0xAA..AA, grant_o returns to 00.
- Simultaneous requests from reset: m0 read 0x100 and m1 write 0x200 at the same cycle → port 0 served first (grant_o = 01). After its ack, one IDLE cycle, then port 1 is served with mem_write_o = 1 and mem_addr_o = 0x200.
- Fairness: both ports hold enable continuously over 4 transactions → grant sequence 01, 10, 01, 10; no port is starved.
- Capture stability: m1 changes addr from 0x300 to 0x380 two cycles after grant → mem_addr_o stays 0x300 until ack.
- Timeout with TIMEOUT = 8: memory never acks → err_o = 1 on the 8th BUSY cycle and stays 1. A subsequent ack still completes with m*_ack_o = 1; err_o clears only on rst_i.
- Reset mid-transaction: rst_i asserted 3 cycles into BUSY1 → the next cycle has all outputs 0 and grant_o = 00. A mem_ack_i arriving after reset produces no m1_ack_o. A new m0 request is then granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port indices and default widths for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker (req, last granted index) -> one-hot grant
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  assign grant = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of Data_Memory between icache (m0, read-only) and dcache (m1), registered mem_* side, sticky timeout err_o
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_ack_o,
  output logic [LINE_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state;
  logic last;
  logic [CW-1:0] cnt;
  logic [1:0] pick;
  rr_pick2 u_pick (.req({m1_enable_i, m0_enable_i}), .last(last), .grant(pick));
  assign m0_ack_o  = state == BUSY0 && mem_ack_i;
  assign m1_ack_o  = state == BUSY1 && mem_ack_i;
  assign m0_data_o = m0_ack_o ? mem_data_i : '0;
  assign m1_data_o = m1_ack_o ? mem_data_i : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last         <= 1'b1;
      cnt          <= '0;
      err_o        <= 1'b0;
      grant_o      <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else if (state == IDLE) begin
      if (|pick) begin
        state        <= pick[P0] ? BUSY0 : BUSY1;
        grant_o      <= pick;
        mem_enable_o <= 1'b1;
        mem_write_o  <= pick[P1] && m1_write_i;
        mem_addr_o   <= pick[P0] ? m0_addr_i : m1_addr_i;
        mem_data_o   <= pick[P0] ? '0 : m1_data_i;
        cnt          <= '0;
      end
    end else if (mem_ack_i) begin
      state        <= IDLE;
      last         <= state == BUSY1;
      grant_o      <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      cnt   <= cnt == CW'(TIMEOUT - 1) ? cnt : cnt + CW'(1);
      err_o <= err_o || cnt >= CW'(TIMEOUT - 2);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mem_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_en = 1'b0, m1_en = 1'b0, m1_wr = 1'b0, mem_ack = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [255:0] m1_wdata = '0, mem_rdata = '0;
  logic m0_ack, m1_ack, mem_en, mem_wr, err;
  logic [255:0] m0_rdata, m1_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic [1:0] grant;
  int vectors = 0, miscompares = 0;
  int own = -1, mlast = 1, age = 0;
  logic merr = 1'b0, cwr = 1'b0, armed = 1'b0;
  logic [31:0] caddr = '0;
  logic [255:0] cdata = '0;
  localparam logic [255:0] AA = {32{8'hAA}};
  localparam logic [255:0] FIVE = {32{8'h55}};

  mem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_enable_i(m0_en), .m0_addr_i(m0_addr), .m0_ack_o(m0_ack), .m0_data_o(m0_rdata),
    .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_data_o(m1_rdata),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdata), .grant_o(grant), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: who owns the memory, what it captured, and how many BUSY cycles it has lasted.
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      own = -1;
      mlast = 1;
      merr = 1'b0;
      age = 0;
    end else if (own < 0) begin
      if (m0_en && m1_en) own = (mlast == 0) ? 1 : 0;
      else if (m0_en) own = 0;
      else if (m1_en) own = 1;
      if (own >= 0) begin
        caddr = own == 0 ? m0_addr : m1_addr;
        cwr   = own == 1 && m1_wr;
        cdata = own == 1 ? m1_wdata : '0;
        age   = 1;
      end
    end else if (mem_ack) begin
      mlast = own;
      own = -1;
    end else begin
      age++;
    end
    if (!rst && own >= 0 && age >= TO) merr = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("grant", 256'(grant), own < 0 ? 256'd0 : own == 0 ? 256'd1 : 256'd2);
      chk("mem_enable", 256'(mem_en), 256'(own >= 0));
      chk("mem_write", 256'(mem_wr), 256'(own >= 0 && cwr));
      chk("mem_addr", 256'(mem_addr), own >= 0 ? 256'(caddr) : 256'd0);
      chk("mem_data", mem_wdata, own >= 0 ? cdata : 256'd0);
      chk("m0_ack", 256'(m0_ack), 256'(own == 0 && mem_ack));
      chk("m1_ack", 256'(m1_ack), 256'(own == 1 && mem_ack));
      chk("err", 256'(err), 256'(merr));
      if (own == 0 && mem_ack) chk("m0_data", m0_rdata, mem_rdata);
      if (own == 1 && mem_ack) chk("m1_data", m1_rdata, mem_rdata);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    #1;
    chk("rst_grant", 256'(grant), 256'd0);
    chk("rst_enable", 256'(mem_en), 256'd0);
    chk("rst_err", 256'(err), 256'd0);
    // single m1 read, ack on the 10th BUSY cycle
    m1_en = 1'b1; m1_wr = 1'b0; m1_addr = 32'h0000_0400;
    step(1);
    m1_en = 1'b0;
    #1;
    chk("rd_enable", 256'(mem_en), 256'd1);
    chk("rd_write", 256'(mem_wr), 256'd0);
    chk("rd_addr", 256'(mem_addr), 256'h400);
    chk("rd_grant", 256'(grant), 256'd2);
    step(9);
    mem_ack = 1'b1; mem_rdata = AA;
    #1;
    chk("rd_ack", 256'(m1_ack), 256'd1);
    chk("rd_data", m1_rdata, AA);
    chk("rd_m0_ack", 256'(m0_ack), 256'd0);
    chk("rd_err_late", 256'(err), 256'd1);
    step(1);
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("rd_idle_grant", 256'(grant), 256'd0);
    chk("rd_ack_pulse", 256'(m1_ack), 256'd0);
    do_reset();
    // simultaneous requests from reset: port 0 first
    m0_en = 1'b1; m0_addr = 32'h100;
    m1_en = 1'b1; m1_wr = 1'b1; m1_addr = 32'h200; m1_wdata = FIVE;
    step(1);
    m0_en = 1'b0;
    #1;
    chk("sim_grant0", 256'(grant), 256'd1);
    chk("sim_addr0", 256'(mem_addr), 256'h100);
    step(2);
    mem_ack = 1'b1;
    #1;
    chk("sim_ack0", 256'(m0_ack), 256'd1);
    step(1);
    mem_ack = 1'b0;
    #1;
    chk("sim_idle", 256'(grant), 256'd0);
    step(1);
    chk("sim_grant1", 256'(grant), 256'd2);
    chk("sim_write1", 256'(mem_wr), 256'd1);
    chk("sim_addr1", 256'(mem_addr), 256'h200);
    chk("sim_wdata1", mem_wdata, FIVE);
    m1_en = 1'b0; m1_wr = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("sim_ack1", 256'(m1_ack), 256'd1);
    step(1);
    mem_ack = 1'b0;
    do_reset();
    // fairness with both enables held
    m0_en = 1'b1; m1_en = 1'b1; m0_addr = 32'h10; m1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("rr_grant", 256'(grant), i % 2 ? 256'd2 : 256'd1);
      mem_ack = 1'b1;
      #1;
      chk("rr_ack", 256'({m1_ack, m0_ack}), i % 2 ? 256'd2 : 256'd1);
      step(1);
      mem_ack = 1'b0;
      #1;
      chk("rr_idle", 256'(grant), 256'd0);
    end
    m0_en = 1'b0; m1_en = 1'b0;
    do_reset();
    // capture stability
    m1_en = 1'b1; m1_addr = 32'h300;
    step(3);
    m1_addr = 32'h380;
    step(3);
    chk("cap_addr", 256'(mem_addr), 256'h300);
    mem_ack = 1'b1;
    #1;
    chk("cap_ack", 256'(m1_ack), 256'd1);
    chk("cap_addr_ack", 256'(mem_addr), 256'h300);
    m1_en = 1'b0;
    step(1);
    mem_ack = 1'b0;
    do_reset();
    // timeout: err appears on the 8th BUSY cycle and is sticky
    m0_en = 1'b1; m0_addr = 32'h40;
    step(1);
    m0_en = 1'b0;
    step(6);
    chk("to_err7", 256'(err), 256'd0);
    step(1);
    chk("to_err8", 256'(err), 256'd1);
    step(3);
    chk("to_err_hold", 256'(err), 256'd1);
    chk("to_still_busy", 256'(grant), 256'd1);
    mem_ack = 1'b1;
    #1;
    chk("to_ack", 256'(m0_ack), 256'd1);
    step(1);
    mem_ack = 1'b0;
    #1;
    chk("to_err_sticky", 256'(err), 256'd1);
    do_reset();
    #1;
    chk("to_err_clr", 256'(err), 256'd0);
    // reset mid-transaction
    m1_en = 1'b1; m1_addr = 32'h500;
    step(1);
    m1_en = 1'b0;
    step(2);
    do_reset();
    #1;
    chk("mid_grant", 256'(grant), 256'd0);
    chk("mid_enable", 256'(mem_en), 256'd0);
    chk("mid_addr", 256'(mem_addr), 256'd0);
    mem_ack = 1'b1;
    #1;
    chk("mid_late_ack", 256'(m1_ack), 256'd0);
    m0_en = 1'b1; m1_en = 1'b1; m0_addr = 32'h600;
    step(1);
    mem_ack = 1'b0;
    m0_en = 1'b0; m1_en = 1'b0;
    #1;
    chk("mid_new_grant", 256'(grant), 256'd1);
    chk("mid_new_addr", 256'(mem_addr), 256'h600);
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
